// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline sequencing controller:
//   halt-drain FSM state encodings, forward-select codes and the
//   field widths of one scoreboard entry {valid, wen, wreg, is_load}.
//   Optional feature macro: HAZARD_FORWARD_EN (consumed by hazard_ctrl).
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam int unsigned SB_VALID_W = 1;
    localparam int unsigned SB_WEN_W   = 1;
    localparam int unsigned SB_WREG_W  = 3;
    localparam int unsigned SB_LOAD_W  = 1;
    localparam int unsigned SB_ENTRY_W = SB_VALID_W + SB_WEN_W + SB_WREG_W + SB_LOAD_W;

    // Entry 0 (producer now in EX, reaching EX/MEM next cycle) wins over entry 1.
    function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem);
        if (hit_ex)
            return FWD_EXMEM;
        else if (hit_mem)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match
//   Compares one decode source register against every scoreboard entry.
//   Ports:
//     src_sel     - source register select
//     src_used    - source is actually read by the decode instruction
//     sb_valid    - per-entry valid bits (entry 0 = EX)
//     sb_wen      - per-entry register-write enables
//     sb_wreg     - per-entry destination registers
//     ex_is_load  - entry 0 holds a load
//     hit         - per-entry RAW match vector
//     hit_is_load - the entry 0 match is a load (load-use hazard)
module hazard_match #(
    parameter int unsigned REG_BITS   = 3,
    parameter int unsigned NUM_STAGES = 3
) (
    input  logic [REG_BITS-1:0]                   src_sel,
    input  logic                                  src_used,
    input  logic [NUM_STAGES-1:0]                 sb_valid,
    input  logic [NUM_STAGES-1:0]                 sb_wen,
    input  logic [NUM_STAGES-1:0][REG_BITS-1:0]   sb_wreg,
    input  logic                                  ex_is_load,
    output logic [NUM_STAGES-1:0]                 hit,
    output logic                                  hit_is_load
);

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            hit[i] = src_used & sb_valid[i] & sb_wen[i] & (sb_wreg[i] == src_sel);
        end
        hit_is_load = hit[0] & ex_is_load;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage 16-bit core. Tracks
//   in-flight register writes in a scoreboard shift register (entry 0 = EX,
//   1 = MEM, 2 = WB), generates stall / bubble / flush controls for the
//   fetch and decode latches, and runs the halt-drain FSM.
//   Optional feature: define HAZARD_FORWARD_EN to stall only on load-use and
//   drive registered forward selects; otherwise every RAW against EX or MEM
//   stalls and the forward selects are tied to the register file.
//   Ports:
//     clk, rst         - clock, asynchronous active-high reset
//     id_*             - decode instruction: valid, sources, destination,
//                        RegWrite, load, HALT
//     ex_redirect      - taken branch/jump resolved in EX
//     stall            - hold PC and IF/ID, bubble into ID/EX
//     pc_write_en      - PC register enable
//     ifid_write_en    - IF/ID latch enable
//     flush_id         - squash IF/ID contents
//     flush_ex         - load a bubble into ID/EX
//     fwd_a_sel/b_sel  - EX operand sources (0 RF, 1 EX/MEM, 2 MEM/WB)
//     halted           - pipeline drained after HALT
//     err              - one-cycle protocol-violation pulse
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_BITS   = 3,
    parameter int unsigned NUM_STAGES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs_sel,
    input  logic                id_rs_used,
    input  logic [REG_BITS-1:0] id_rt_sel,
    input  logic                id_rt_used,
    input  logic [REG_BITS-1:0] id_wr_sel,
    input  logic                id_wr_en,
    input  logic                id_mem_read,
    input  logic                id_halt,
    input  logic                ex_redirect,
    output logic                stall,
    output logic                pc_write_en,
    output logic                ifid_write_en,
    output logic                flush_id,
    output logic                flush_ex,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic                halted,
    output logic                err
);

    hz_state_t state, state_next;

    logic [NUM_STAGES-1:0]               sb_valid;
    logic [NUM_STAGES-1:0]               sb_wen;
    logic [NUM_STAGES-1:0]               sb_load;
    logic [NUM_STAGES-1:0][REG_BITS-1:0] sb_wreg;

    logic [NUM_STAGES-1:0] hit_a, hit_b;
    logic                  load_a, load_b;
    logic                  hazard_raw;
    logic                  advance;

    hazard_match #(
        .REG_BITS   (REG_BITS),
        .NUM_STAGES (NUM_STAGES)
    ) u_match_a (
        .src_sel     (id_rs_sel),
        .src_used    (id_rs_used),
        .sb_valid    (sb_valid),
        .sb_wen      (sb_wen),
        .sb_wreg     (sb_wreg),
        .ex_is_load  (sb_load[0]),
        .hit         (hit_a),
        .hit_is_load (load_a)
    );

    hazard_match #(
        .REG_BITS   (REG_BITS),
        .NUM_STAGES (NUM_STAGES)
    ) u_match_b (
        .src_sel     (id_rt_sel),
        .src_used    (id_rt_used),
        .sb_valid    (sb_valid),
        .sb_wen      (sb_wen),
        .sb_wreg     (sb_wreg),
        .ex_is_load  (sb_load[0]),
        .hit         (hit_b),
        .hit_is_load (load_b)
    );

`ifdef HAZARD_FORWARD_EN
    assign hazard_raw = id_valid & (load_a | load_b);

    logic unused_hits;
    assign unused_hits = &{1'b0, hit_a[NUM_STAGES-1], hit_b[NUM_STAGES-1]};
`else
    // The WB entry is not checked: the register file bypasses a same-cycle write.
    assign hazard_raw = id_valid & ((|hit_a[1:0]) | (|hit_b[1:0]));

    logic unused_hits;
    assign unused_hits = &{1'b0, hit_a[NUM_STAGES-1], hit_b[NUM_STAGES-1], load_a, load_b};
`endif

    // Redirect takes priority over a stall and squashes a HALT in decode.
    always_comb begin
        stall         = 1'b0;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        flush_id      = 1'b0;
        flush_ex      = 1'b0;
        halted        = 1'b0;
        state_next    = state;
        unique case (state)
            ST_RUN: begin
                if (ex_redirect) begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (hazard_raw) begin
                    stall         = 1'b1;
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    flush_ex      = 1'b1;
                end else if (id_valid & id_halt) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                flush_ex      = 1'b1;
                if (sb_valid == '0)
                    state_next = ST_HALTED;
            end
            ST_HALTED: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                flush_ex      = 1'b1;
                halted        = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign advance = (state == ST_RUN) & id_valid & ~stall & ~ex_redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    // Entry NUM_STAGES-1 falls off the top; a non-advancing cycle inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            sb_wen   <= '0;
            sb_load  <= '0;
            sb_wreg  <= '0;
        end else begin
            sb_valid <= {sb_valid[NUM_STAGES-2:0], advance};
            sb_wen   <= {sb_wen[NUM_STAGES-2:0],   advance & id_wr_en};
            sb_load  <= {sb_load[NUM_STAGES-2:0],  advance & id_mem_read};
            sb_wreg  <= {sb_wreg[NUM_STAGES-2:0],  advance ? id_wr_sel : {REG_BITS{1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else
            err <= (ex_redirect & (state != ST_RUN)) | (id_valid & (state == ST_HALTED));
    end

`ifdef HAZARD_FORWARD_EN
    // Matches are taken against the pre-shift scoreboard, so the entry 0
    // producer is in EX/MEM when the consumer reaches EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (advance) begin
            fwd_a_sel <= fwd_pick(hit_a[0], hit_a[1]);
            fwd_b_sel <= fwd_pick(hit_b[0], hit_b[1]);
        end else begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end
    end
`else
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs_sel = '0;
    logic       id_rs_used = 1'b0;
    logic [2:0] id_rt_sel = '0;
    logic       id_rt_used = 1'b0;
    logic [2:0] id_wr_sel = '0;
    logic       id_wr_en = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       id_halt = 1'b0;
    logic       ex_redirect = 1'b0;
    logic       stall, pc_write_en, ifid_write_en, flush_id, flush_ex;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       halted, err;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_BITS(3), .NUM_STAGES(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs_sel     (id_rs_sel),
        .id_rs_used    (id_rs_used),
        .id_rt_sel     (id_rt_sel),
        .id_rt_used    (id_rt_used),
        .id_wr_sel     (id_wr_sel),
        .id_wr_en      (id_wr_en),
        .id_mem_read   (id_mem_read),
        .id_halt       (id_halt),
        .ex_redirect   (ex_redirect),
        .stall         (stall),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .halted        (halted),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rs_sel = '0; id_rs_used = 1'b0; id_rt_sel = '0; id_rt_used = 1'b0;
        id_wr_sel = '0; id_wr_en = 1'b0; id_mem_read = 1'b0; id_halt = 1'b0; ex_redirect = 1'b0;
    endtask

    task automatic instr(input logic [2:0] rs, input logic rs_u, input logic [2:0] rt, input logic rt_u,
                         input logic [2:0] wr, input logic wen, input logic ld, input logic hlt);
        id_valid = 1'b1; id_rs_sel = rs; id_rs_used = rs_u; id_rt_sel = rt; id_rt_used = rt_u;
        id_wr_sel = wr; id_wr_en = wen; id_mem_read = ld; id_halt = hlt; ex_redirect = 1'b0;
    endtask

    task automatic drain_idle(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (pc_write_en !== 1'b1) begin errors++; $display("FAIL reset_pc_we: got %b want 1", pc_write_en); end
        checks++; if (ifid_write_en !== 1'b1) begin errors++; $display("FAIL reset_ifid_we: got %b want 1", ifid_write_en); end
        checks++; if ({flush_id, flush_ex} !== 2'b00) begin errors++; $display("FAIL reset_flush: got %b want 00", {flush_id, flush_ex}); end
        checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'd0) begin errors++; $display("FAIL reset_fwd: got %h want 0", {fwd_a_sel, fwd_b_sel}); end
        checks++; if ({halted, err} !== 2'b00) begin errors++; $display("FAIL reset_halted_err: got %b want 00", {halted, err}); end
        rst = 1'b0;
        tick();
        checks++; if (pc_write_en !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL post_reset_run: pc_we=%b stall=%b want 1/0", pc_write_en, stall); end
    endtask

    // ADD r3 <- r1,r2 ; then a reader of r3 as rs.
    task automatic test_raw_stall();
        instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_producer_stall: got %b want 0", stall); end
        tick();
        instr(3'd3, 1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        #1;
`ifdef HAZARD_FORWARD_EN
        checks++; if (stall !== 1'b0 || pc_write_en !== 1'b1) begin errors++; $display("FAIL raw_fwd_nostall: stall=%b pc_we=%b want 0/1", stall, pc_write_en); end
        tick();
        idle();
        #1;
        checks++; if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd0) begin errors++; $display("FAIL raw_fwd_sel: a=%0d b=%0d want 1/0", fwd_a_sel, fwd_b_sel); end
`else
        checks++; if ({stall, pc_write_en, ifid_write_en, flush_ex} !== 4'b1001) begin errors++; $display("FAIL raw_stall_c1: stall/pc/ifid/fex=%b want 1001", {stall, pc_write_en, ifid_write_en, flush_ex}); end
        tick();
        checks++; if (stall !== 1'b1 || pc_write_en !== 1'b0) begin errors++; $display("FAIL raw_stall_c2: stall=%b pc_we=%b want 1/0", stall, pc_write_en); end
        tick();
        checks++; if (stall !== 1'b0 || pc_write_en !== 1'b1 || flush_ex !== 1'b0) begin errors++; $display("FAIL raw_release: stall=%b pc_we=%b fex=%b want 0/1/0", stall, pc_write_en, flush_ex); end
        tick();
        idle();
        #1;
        checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("FAIL raw_nofwd_sel: got %0d want 0", fwd_a_sel); end
`endif
        drain_idle(3);
    endtask

    // Producer distance 2 (MEM), distance 3 (WB), and an unused source.
    task automatic test_entry_windows();
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        instr(3'd1, 1'b1, 3'd6, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        #1;
`ifdef HAZARD_FORWARD_EN
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mem_window_stall: got %b want 0", stall); end
        tick();
        idle();
        #1;
        checks++; if (fwd_b_sel !== 2'd2 || fwd_a_sel !== 2'd0) begin errors++; $display("FAIL mem_window_fwd: a=%0d b=%0d want 0/2", fwd_a_sel, fwd_b_sel); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mem_window_stall: got %b want 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_window_release: got %b want 0", stall); end
`endif
        drain_idle(3);
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        instr(3'd5, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_no_stall: got %b want 0", stall); end
        tick();
        idle();
        #1;
        checks++; if (fwd_a_sel !== 2'd0) begin errors++; $display("FAIL wb_fwd_rf: got %0d want 0", fwd_a_sel); end
        drain_idle(3);
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        tick();
        instr(3'd4, 1'b0, 3'd4, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_src_stall: got %b want 0", stall); end
        drain_idle(3);
    endtask

    // LD r2 ; ADD reading r2 as rt.
    task automatic test_load_use();
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        tick();
        instr(3'd0, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1 || flush_ex !== 1'b1) begin errors++; $display("FAIL load_use_c1: stall=%b fex=%b want 1/1", stall, flush_ex); end
        tick();
`ifdef HAZARD_FORWARD_EN
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_c2: got %b want 0", stall); end
        tick();
        idle();
        #1;
        checks++; if (fwd_b_sel !== 2'd2 || fwd_a_sel !== 2'd0) begin errors++; $display("FAIL load_use_fwd: a=%0d b=%0d want 0/2", fwd_a_sel, fwd_b_sel); end
`else
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_c2: got %b want 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_c3: got %b want 0", stall); end
        tick();
        idle();
        #1;
        checks++; if (fwd_b_sel !== 2'd0) begin errors++; $display("FAIL load_use_fwd: got %0d want 0", fwd_b_sel); end
`endif
        drain_idle(3);
    endtask

    task automatic test_redirect();
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        instr(3'd3, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
        ex_redirect = 1'b1;
        #1;
        checks++; if ({stall, flush_id, flush_ex} !== 3'b011) begin errors++; $display("FAIL redirect_ctl: stall/fid/fex=%b want 011", {stall, flush_id, flush_ex}); end
        checks++; if (pc_write_en !== 1'b1) begin errors++; $display("FAIL redirect_pc_we: got %b want 1", pc_write_en); end
        tick();
        idle();
        #1;
        checks++; if ({pc_write_en, flush_ex, halted, err} !== 4'b1000) begin errors++; $display("FAIL redirect_stays_run: pc/fex/halted/err=%b want 1000", {pc_write_en, flush_ex, halted, err}); end
        drain_idle(4);
        checks++; if (pc_write_en !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL redirect_no_drain: pc_we=%b halted=%b want 1/0", pc_write_en, halted); end
    endtask

    task automatic test_halt_drain();
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (stall !== 1'b0 || pc_write_en !== 1'b1) begin errors++; $display("FAIL halt_accept: stall=%b pc_we=%b want 0/1", stall, pc_write_en); end
        tick();
        idle();
        #1;
        checks++; if ({pc_write_en, ifid_write_en, flush_ex, halted} !== 4'b0010) begin errors++; $display("FAIL drain_ctl: pc/ifid/fex/halted=%b want 0010", {pc_write_en, ifid_write_en, flush_ex, halted}); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_edge%0d: halted=%b want 0", k, halted); end
        end
        tick();
        checks++; if ({halted, pc_write_en, ifid_write_en} !== 3'b100) begin errors++; $display("FAIL halted_state: halted/pc/ifid=%b want 100", {halted, pc_write_en, ifid_write_en}); end
        ex_redirect = 1'b1;
        #1;
        checks++; if (flush_id !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL halted_redirect_ignored: fid=%b err=%b want 0/0", flush_id, err); end
        tick();
        ex_redirect = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL halted_redirect_err: got %b want 1", err); end
        tick();
        checks++; if (err !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL err_one_pulse: err=%b halted=%b want 0/1", err, halted); end
        id_valid = 1'b1;
        tick();
        id_valid = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL halted_valid_err: got %b want 1", err); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL halted_valid_err_clear: got %b want 0", err); end
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        instr(3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b want 1", stall); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({stall, pc_write_en, flush_ex} !== 3'b010) begin errors++; $display("FAIL async_reset_stall: stall/pc/fex=%b want 010", {stall, pc_write_en, flush_ex}); end
        rst = 1'b0;
        idle();
        tick();
        instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        checks++; if (pc_write_en !== 1'b0 || flush_ex !== 1'b1) begin errors++; $display("FAIL pre_reset_drain: pc_we=%b fex=%b want 0/1", pc_write_en, flush_ex); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({pc_write_en, ifid_write_en, flush_ex, halted, stall} !== 5'b11000) begin errors++; $display("FAIL async_reset_drain: pc/ifid/fex/halted/stall=%b want 11000", {pc_write_en, ifid_write_en, flush_ex, halted, stall}); end
        rst = 1'b0;
        drain_idle(6);
        checks++; if (pc_write_en !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL reset_exit_run: pc_we=%b halted=%b want 1/0", pc_write_en, halted); end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_entry_windows();
        test_load_use();
        test_redirect();
        test_halt_drain();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 16-bit core.
- Sits beside decode:
  - tracks in-flight register writes in a small scoreboard shift register;
  - generates the stall, bubble-insert and flush controls for the fetch/decode latches;
  - runs the halt-drain state machine.
- Decode supplies the already-muxed write register (R7 for PcToReg); execute supplies the redirect.

Parameters:
- REG_BITS, 3, register-select width (8 GPRs).
- NUM_STAGES, 3, scoreboard depth; entry 0 = EX, 1 = MEM, 2 = WB.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs_sel  in  REG_BITS  source A register (Instruction[10:8]).
- id_rs_used  in  1  source A is read.
- id_rt_sel  in  REG_BITS  source B register (Instruction[7:5]).
- id_rt_used  in  1  source B is read.
- id_wr_sel  in  REG_BITS  destination register, post RegDst/PcToReg mux.
- id_wr_en  in  1  RegWrite of the decode instruction.
- id_mem_read  in  1  decode instruction is a load.
- id_halt  in  1  decode instruction is HALT.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- pc_write_en  out  1  PC register enable.
- ifid_write_en  out  1  IF/ID latch enable.
- flush_id  out  1  squash IF/ID contents (write NOP).
- flush_ex  out  1  load bubble into ID/EX.
- fwd_a_sel  out  2  EX operand A source: 0 = RF, 1 = EX/MEM, 2 = MEM/WB.
- fwd_b_sel  out  2  same, for operand B.
- halted  out  1  pipeline drained after HALT.
- err  out  1  protocol violation, one-cycle pulse.

Interface rule (decided): one clock; reset is asynchronous and active-high, clock port clk, reset port rst.

Behaviour:
- Scoreboard entry: {valid, wen, wreg, is_load}.
  - Every clock, entries shift 0->1->2; entry 2 is discarded.
  - Entry 0 loads the decode instruction when it advances (id_valid & ~stall & ~ex_redirect & state==RUN); otherwise entry 0 loads a bubble (valid=0).
- Hazard match: source used, entry valid, wen=1, wreg equals the source.
  - R0 is not special; all 8 registers are tracked.
- Without FORWARD_EN:
  - stall = id_valid & a match against entry 0 or entry 1.
  - Entry 2 (WB) is not checked; the register file bypasses a same-cycle write to a read.
- stall=1 drives pc_write_en=0, ifid_write_en=0, flush_ex=1.
  - stall, pc_write_en, ifid_write_en, flush_ex and flush_id are combinational from the inputs and registered state.
- ex_redirect=1 drives flush_id=1 and flush_ex=1, forces stall=0 and holds pc_write_en=1 (PC takes the target).
  - Redirect overrides a simultaneous stall and a simultaneous id_halt: the halt is squashed and the state stays RUN.
- FSM states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when id_halt & id_valid & ~stall & ~ex_redirect; the halt enters entry 0.
  - DRAIN: pc_write_en=0, ifid_write_en=0, flush_ex=1. Advance to HALTED in the cycle after all scoreboard valid bits read 0.
  - HALTED: halted=1; PC and IF/ID remain frozen. Exit only by rst.
- err pulses for one cycle on:
  - ex_redirect in DRAIN or HALTED (the redirect is ignored);
  - id_valid in HALTED.
- fwd_a_sel/fwd_b_sel are registered and describe the instruction currently in EX; they are 0 when that instruction is a bubble.
- Reset (async):
  - scoreboard cleared, state RUN, fwd selects 0, err 0;
  - hence stall=0, pc_write_en=1, ifid_write_en=1, flush_id=0, flush_ex=0, halted=0.
- A reset asserted mid-stall or mid-drain returns immediately to these values.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined:
  - stall only on a load-use hazard, i.e. a match against entry 0 with is_load=1.
  - Otherwise each operand's forward select is registered: 1 if it matches entry 0, else 2 if it matches entry 1, else 0. Entry 0 has priority.
- Undefined: fwd_a_sel and fwd_b_sel are tied to 0 and the full stall rule applies.

Decomposition:
- Shared package holds:
  - FSM state encodings (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2);
  - FWD_RF/FWD_EXMEM/FWD_MEMWB constants;
  - the scoreboard entry field widths.
- One natural sub-module: hazard_match. Combinational; compares one source against all entries and returns the hit vector and is_load.

Test Plan:
- ADD writing R3, next instruction reads R3 as rs (no forwarding) -> stall=1 for 2 cycles, pc_write_en=0; the consumer enters EX on cycle 3.
- Same sequence with HAZARD_FORWARD_EN -> stall=0; the consumer in EX sees fwd_a_sel=1.
- With HAZARD_FORWARD_EN, LD R2 then ADD reading R2 as rt -> 1 stall cycle, then fwd_b_sel=2.
- ex_redirect coincident with a stall condition and id_halt -> flush_id=1, flush_ex=1, stall=0, state stays RUN.
- HALT with 2 older writes in flight -> DRAIN, then halted=1 exactly when the scoreboard empties; a later ex_redirect gives err=1 for one cycle.
- rst asserted mid-DRAIN between clock edges -> outputs return to reset values immediately, without waiting for a clock edge.
